scoreboard_stall_ctrl: RTL and testbench

//  Parametrised stall controller for the 5-stage RISCV core; replaces opcode-specific load-use checks.

---
 rtl/scoreboard_stall_ctrl.sv | 58 +++++
 tb/tb_scoreboard_stall_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/scoreboard_stall_ctrl.sv
// scoreboard_stall_ctrl: per-register countdown scoreboard driving ID stall and bubble insertion
// Optional saturating stall counter enabled by defining SCB_PERF_CNT_EN
module scoreboard_stall_ctrl #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 4,
  parameter int LAT_W      = 3,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ID_valid_ip,
  input  logic [REG_ADDR_W-1:0] ID_src1_addr_ip,
  input  logic                  ID_src1_used_ip,
  input  logic [REG_ADDR_W-1:0] ID_src2_addr_ip,
  input  logic                  ID_src2_used_ip,
  input  logic [REG_ADDR_W-1:0] ID_rd_addr_ip,
  input  logic                  ID_rd_we_ip,
  input  logic [LAT_W-1:0]      ID_fwd_lat_ip,
  input  logic                  flush_ip,
  output logic                  stall_op,
  output logic                  haz_src1_op,
  output logic                  haz_src2_op,
  output logic [PERF_W-1:0]     stall_cnt_op
);
  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];
  logic [LAT_W-1:0] lat_c;
  logic haz1, haz2, waw, stall, issue;
  always_comb begin
    lat_c = (ID_fwd_lat_ip > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : ID_fwd_lat_ip;
    haz1  = ID_valid_ip & ID_src1_used_ip & (ID_src1_addr_ip != '0) & (cnt_q[ID_src1_addr_ip] != '0);
    haz2  = ID_valid_ip & ID_src2_used_ip & (ID_src2_addr_ip != '0) & (cnt_q[ID_src2_addr_ip] != '0);
    waw   = ID_valid_ip & ID_rd_we_ip & (ID_rd_addr_ip != '0) & (cnt_q[ID_rd_addr_ip] > lat_c);
    stall = (haz1 | haz2 | waw) & ~flush_ip & reset;
    issue = ID_valid_ip & ~stall & ~flush_ip & ID_rd_we_ip & (ID_rd_addr_ip != '0);
    cnt_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++)
      cnt_d[r] = (issue && ID_rd_addr_ip == REG_ADDR_W'(r)) ? lat_c :
                 (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    else        for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
  assign stall_op    = stall;
  assign haz_src1_op = haz1 & reset;
  assign haz_src2_op = haz2 & reset;
`ifdef SCB_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q, perf_d;
  assign perf_d = (stall && !(&perf_q)) ? perf_q + 1'b1 : perf_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  assign stall_cnt_op = perf_q;
`else
  assign stall_cnt_op = '0;
`endif
endmodule

// File: tb/tb_scoreboard_stall_ctrl.sv
// tb_scoreboard_stall_ctrl: directed + random checks against a ready-cycle reference model
module tb_scoreboard_stall_ctrl;
  logic clk = 0, reset = 0;
  logic v, u1, u2, we, fl;
  logic [4:0] s1, s2, rd;
  logic [2:0] lat;
  logic stall_op, h1, h2, stall4, h14, h24;
  logic [31:0] scnt;
  logic [3:0]  scnt4;
  int compared = 0, mismatched = 0;
  int ready_at [32];
  int cycle = 0;
  longint exp_cnt = 0;
  logic obs_stall;

  always #5 clk = ~clk;

  scoreboard_stall_ctrl dut (.clk(clk), .reset(reset), .ID_valid_ip(v), .ID_src1_addr_ip(s1),
    .ID_src1_used_ip(u1), .ID_src2_addr_ip(s2), .ID_src2_used_ip(u2), .ID_rd_addr_ip(rd),
    .ID_rd_we_ip(we), .ID_fwd_lat_ip(lat), .flush_ip(fl), .stall_op(stall_op),
    .haz_src1_op(h1), .haz_src2_op(h2), .stall_cnt_op(scnt));

  scoreboard_stall_ctrl #(.PERF_W(4)) dut4 (.clk(clk), .reset(reset), .ID_valid_ip(v),
    .ID_src1_addr_ip(s1), .ID_src1_used_ip(u1), .ID_src2_addr_ip(s2), .ID_src2_used_ip(u2),
    .ID_rd_addr_ip(rd), .ID_rd_we_ip(we), .ID_fwd_lat_ip(lat), .flush_ip(fl),
    .stall_op(stall4), .haz_src1_op(h14), .haz_src2_op(h24), .stall_cnt_op(scnt4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic int rem(input logic [4:0] r);
    int d;
    d = ready_at[r] - cycle + 1;
    return (r == 0 || d < 0) ? 0 : d;
  endfunction

  function automatic logic [31:0] exp_perf(input int w);
    longint m;
    m = (64'd1 << w) - 1;
`ifdef SCB_PERF_CNT_EN
    return 32'(exp_cnt > m ? m : exp_cnt);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) ready_at[r] = -100;
    exp_cnt = 0;
  endtask

  task automatic cyc(input logic iv, input logic [4:0] a1, input logic iu1, input logic [4:0] a2,
                     input logic iu2, input logic [4:0] ard, input logic iwe, input logic [2:0] il,
                     input logic ifl);
    int lc;
    logic e1, e2, ew, es;
    v = iv; s1 = a1; u1 = iu1; s2 = a2; u2 = iu2; rd = ard; we = iwe; lat = il; fl = ifl;
    #1;
    lc = (il > 4) ? 4 : int'(il);
    e1 = iv && iu1 && a1 != 0 && rem(a1) != 0;
    e2 = iv && iu2 && a2 != 0 && rem(a2) != 0;
    ew = iv && iwe && ard != 0 && rem(ard) > lc;
    es = (e1 || e2 || ew) && !ifl;
    chk("stall", {31'd0, stall_op}, {31'd0, es});
    chk("haz1", {31'd0, h1}, {31'd0, e1});
    chk("haz2", {31'd0, h2}, {31'd0, e2});
    chk("stall_cnt", scnt, exp_perf(32));
    chk("stall_cnt4", {28'd0, scnt4}, exp_perf(4));
    obs_stall = stall_op;
    @(posedge clk);
    if (iv && !es && !ifl && iwe && ard != 0) ready_at[ard] = cycle + lc;
    if (es) exp_cnt++;
    cycle++;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    v = 1; s1 = 5; u1 = 1; s2 = 6; u2 = 1; rd = 5; we = 1; lat = 4; fl = 0;
    #12;
    chk("rst_stall", {31'd0, stall_op}, 0);
    chk("rst_cnt", scnt, 0);
    @(negedge clk); reset = 1;
    idle();
    // LOAD x5 then dependent ADD: exactly one bubble
    cyc(1, 0, 0, 0, 0, 5, 1, 1, 0);
    cyc(1, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("load_use_stall", {31'd0, obs_stall}, 1);
    cyc(1, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("load_use_go", {31'd0, obs_stall}, 0);
    // ALU producer never stalls
    cyc(1, 1, 1, 2, 1, 5, 1, 0, 0);
    cyc(1, 5, 1, 5, 1, 7, 1, 0, 0);
    chk("alu_nostall", {31'd0, obs_stall}, 0);
    // MUL x3 lat 4, then WAW write to x3 lat 0
    cyc(1, 1, 1, 2, 1, 3, 1, 4, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0);
    chk("waw_release", {31'd0, obs_stall}, 0);
    // MUL x3 lat 4 then dependent ADDI: four stalls
    cyc(1, 1, 1, 2, 1, 3, 1, 4, 0);
    for (int i = 0; i < 4; i++) cyc(1, 3, 1, 0, 0, 4, 1, 0, 0);
    cyc(1, 3, 1, 0, 0, 4, 1, 0, 0);
    chk("mul_dep_go", {31'd0, obs_stall}, 0);
    // x0 is never tracked
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 1, 1, 1, 0, 0);
    chk("x0_nostall", {31'd0, obs_stall}, 0);
    // flush overrides stall, counter still decays
    cyc(1, 0, 0, 0, 0, 8, 1, 2, 0);
    cyc(1, 8, 1, 0, 0, 9, 1, 0, 1);
    chk("flush_nostall", {31'd0, obs_stall}, 0);
    cyc(1, 8, 1, 0, 0, 9, 1, 0, 0);
    cyc(1, 8, 1, 0, 0, 9, 1, 0, 0);
    // clamp: latency 7 behaves as 4
    cyc(1, 0, 0, 0, 0, 10, 1, 7, 0);
    for (int i = 0; i < 5; i++) cyc(1, 10, 1, 0, 0, 11, 1, 0, 0);
    // mid-operation async reset
    cyc(1, 0, 0, 0, 0, 9, 1, 4, 0);
    idle();
    v = 1; s1 = 9; u1 = 1; u2 = 0; rd = 12; we = 1; lat = 0; fl = 0;
    #1 chk("pre_rst_stall", {31'd0, stall_op}, 1);
    #1 reset = 0;
    #1;
    chk("async_rst_stall", {31'd0, stall_op}, 0);
    chk("async_rst_haz1", {31'd0, h1}, 0);
    chk("async_rst_cnt", scnt, 0);
    model_reset();
    @(negedge clk); reset = 1;
    cyc(1, 9, 1, 0, 0, 12, 1, 0, 0);
    chk("post_rst_nostall", {31'd0, obs_stall}, 0);
    // random traffic over a small register window
    repeat (400)
      cyc(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
          1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 9) == 0));
    if (exp_cnt >= 15) chk("sat4_final", {28'd0, scnt4}, exp_perf(4));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
